// File: rtl/alu_nibble_seq_pkg.sv
// Shared constants, op codes, ALU slice codes and FSM state type for alu_nibble_seq.

package alu_nibble_seq_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned NIB_N  = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_SEQ = 3'b111;

   // Slice codes; logic codes coincide with the request op codes.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_NOT = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   function automatic logic [NIB_W-1:0] nib_sel(input logic [WORD_W-1:0] w,
                                                input logic [1:0]        idx);
      logic [WORD_W-1:0] sh;
      sh = w >> (idx * NIB_W);
      return sh[NIB_W-1:0];
   endfunction

endpackage

// File: rtl/alu_nibble_seq.sv
// 16-bit ALU sequencer driving an external 4-bit slice one nibble per cycle, LSB first.
// Define ALU_NIBBLE_SEQ_FLAGS_EN to compute out_zero/out_carry/out_overflow; otherwise tied 0.

module alu_nibble_seq
   import alu_nibble_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [WORD_W-1:0] in_a,
   input  logic [WORD_W-1:0] in_b,
   input  logic              in_cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_carry,
   output logic              out_overflow,
   output logic [NIB_W-1:0]  alu_a,
   output logic [NIB_W-1:0]  alu_b,
   output logic [2:0]        alu_c,
   output logic              alu_cin,
   input  logic [NIB_W-1:0]  alu_result,
   input  logic              alu_carry,
   input  logic              alu_overflow
);

   state_t            r_state, w_state_d;
   logic [1:0]        r_idx;
   logic [2:0]        r_op;
   logic [WORD_W-1:0] r_a, r_b, r_res, r_out_result;
   logic              r_cin, r_carry, r_ovf, r_out_valid;
   logic              w_sub, w_accept, w_finalize;
   logic [WORD_W-1:0] w_final, w_nib_mask, w_nib_ins;

   assign w_sub      = (r_op == OP_SUB) || (r_op == OP_SLT) || (r_op == OP_SEQ);
   assign w_accept   = in_valid & in_ready;
   assign w_finalize = (r_state == StDone) & ~r_out_valid;
   assign in_ready   = (r_state == StIdle);
   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_d = StRun;
         StRun:   if (r_idx == 2'(NIB_N - 1)) w_state_d = StDone;
         StDone:  if (r_out_valid && out_ready) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Subtract-class ops run as a + ~b + 1 through the slice's add code.
   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_c   = ALU_ADD;
      alu_cin = 1'b0;
      if (r_state == StRun) begin
         alu_a = nib_sel(r_a, r_idx);
         if (w_sub) begin
            alu_b   = ~nib_sel(r_b, r_idx);
            alu_cin = (r_idx == 2'd0) ? 1'b1 : r_carry;
         end else if (r_op == OP_ADD) begin
            alu_b   = nib_sel(r_b, r_idx);
            alu_cin = (r_idx == 2'd0) ? r_cin : r_carry;
         end else begin
            alu_b = nib_sel(r_b, r_idx);
            alu_c = r_op;
         end
      end
   end

   always_comb begin
      w_nib_mask = {{(WORD_W - NIB_W){1'b0}}, {NIB_W{1'b1}}} << (r_idx * NIB_W);
      w_nib_ins  = {{(WORD_W - NIB_W){1'b0}}, alu_result} << (r_idx * NIB_W);
      w_final    = r_res;
      if (r_op == OP_SLT) begin
         w_final = {{(WORD_W - 1){1'b0}}, r_res[WORD_W-1] ^ r_ovf};
      end else if (r_op == OP_SEQ) begin
         w_final = {{(WORD_W - 1){1'b0}}, (r_res == '0)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_idx        <= 2'd0;
         r_op         <= OP_ADD;
         r_a          <= '0;
         r_b          <= '0;
         r_cin        <= 1'b0;
         r_carry      <= 1'b0;
         r_ovf        <= 1'b0;
         r_res        <= '0;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
      end else begin
         r_state <= w_state_d;
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_op  <= in_op;
                  r_a   <= in_a;
                  r_b   <= in_b;
                  r_cin <= in_cin;
                  r_idx <= 2'd0;
               end
            end
            StRun: begin
               r_res   <= (r_res & ~w_nib_mask) | w_nib_ins;
               r_carry <= alu_carry;
               r_ovf   <= alu_overflow;
               r_idx   <= r_idx + 2'd1;
            end
            StDone: begin
               // First DONE cycle folds the raw difference into the SLT/SEQ answer.
               if (!r_out_valid) begin
                  r_out_valid  <= 1'b1;
                  r_out_result <= w_final;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
   logic r_out_zero, r_out_carry, r_out_ovf;
   logic w_arith;

   assign w_arith = (r_op == OP_ADD) || w_sub;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_zero  <= 1'b0;
         r_out_carry <= 1'b0;
         r_out_ovf   <= 1'b0;
      end else if (w_finalize) begin
         r_out_zero  <= (w_final == '0);
         r_out_carry <= w_arith & r_carry;
         r_out_ovf   <= w_arith & r_ovf;
      end
   end

   assign out_zero     = r_out_zero;
   assign out_carry    = r_out_carry;
   assign out_overflow = r_out_ovf;
`else
   logic w_unused;
   assign w_unused     = w_finalize;
   assign out_zero     = 1'b0;
   assign out_carry    = 1'b0;
   assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: behavioural 4-bit slice, word-level reference model,
// queue scoreboard with an independent response monitor.

module tb_alu_nibble_seq;

   localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_XOR = 3'd5, T_SLT = 3'd6, T_SEQ = 3'd7;

   typedef struct {
      logic [15:0] res;
      logic        z, c, v;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_cin, out_valid, out_ready;
   logic [2:0]  in_op, alu_c;
   logic [15:0] in_a, in_b, out_result;
   logic        out_zero, out_carry, out_overflow, alu_cin, alu_carry, alu_overflow;
   logic [3:0]  alu_a, alu_b, alu_result;
   logic [4:0]  slice_sum;

   exp_t        q[$];
   exp_t        mon_e;
   logic [18:0] mon_hold;
   bit          mon_seen = 1'b0;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   int          rdy_mode = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_nibble_seq dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_cin       (in_cin),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_zero     (out_zero),
      .out_carry    (out_carry),
      .out_overflow (out_overflow),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_c        (alu_c),
      .alu_cin      (alu_cin),
      .alu_result   (alu_result),
      .alu_carry    (alu_carry),
      .alu_overflow (alu_overflow)
   );

   // External 4-bit slice
   always_comb begin
      slice_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      alu_result   = 4'h0;
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      case (alu_c)
         3'b000: begin
            alu_result   = slice_sum[3:0];
            alu_carry    = slice_sum[4];
            alu_overflow = (alu_a[3] == alu_b[3]) && (slice_sum[3] != alu_a[3]);
         end
         3'b010:  alu_result = ~alu_a;
         3'b011:  alu_result = alu_a & alu_b;
         3'b100:  alu_result = alu_a | alu_b;
         3'b101:  alu_result = alu_a ^ alu_b;
         default: alu_result = 4'h0;
      endcase
   end

   task automatic chk_eq(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin);
      exp_t        e;
      logic [16:0] s;
      e.c = 1'b0;
      e.v = 1'b0;
      e.acc = 0;
      e.res = 16'h0;
      if (op == T_ADD) begin
         s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
         e.res = s[15:0];
         e.c = s[16];
         e.v = (a[15] == b[15]) && (s[15] != a[15]);
      end else if (op inside {T_SUB, T_SLT, T_SEQ}) begin
         s = {1'b0, a} - {1'b0, b};
         e.c = (a >= b);
         e.v = (a[15] != b[15]) && (s[15] != a[15]);
         if (op == T_SUB)      e.res = s[15:0];
         else if (op == T_SLT) e.res = ($signed(a) < $signed(b)) ? 16'h1 : 16'h0;
         else                  e.res = (a == b) ? 16'h1 : 16'h0;
      end else begin
         case (op)
            3'd2:    e.res = ~a;
            3'd3:    e.res = a & b;
            3'd4:    e.res = a | b;
            default: e.res = a ^ b;
         endcase
      end
      e.z = (e.res == 16'h0);
`ifndef ALU_NIBBLE_SEQ_FLAGS_EN
      e.z = 1'b0;
      e.c = 1'b0;
      e.v = 1'b0;
`endif
      return e;
   endfunction

   // Expected {alu_a, alu_b, alu_c, alu_cin} while nibble i is issued.
   function automatic logic [11:0] exp_alu(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin, input int i);
      int unsigned av, bv, m, ci;
      bit          sub, lg;
      logic [3:0]  an, bn;
      sub = op inside {T_SUB, T_SLT, T_SEQ};
      lg  = !sub && (op != T_ADD);
      av  = a;
      bv  = sub ? 32'(~b) : 32'(b);
      if (lg)          ci = 0;
      else if (i == 0) ci = sub ? 1 : 32'(cin);
      else begin
         m  = (32'd1 << (4 * i)) - 1;
         ci = ((av & m) + (bv & m) + (sub ? 1 : 32'(cin))) >> (4 * i);
      end
      an = 4'((av >> (4 * i)) & 15);
      bn = 4'((bv >> (4 * i)) & 15);
      return {an, bn, (lg ? op : 3'b000), ci[0]};
   endfunction

   // Call at a negedge; returns at the negedge of the last RUN cycle.
   task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin);
      exp_t e;
      int   n;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_chk++;
         n_err++;
         $display("FAIL accept_timeout: in_ready got 0 for 100 cycles, required 1");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e = model(op, a, b, cin);
      e.acc = cyc;
      q.push_back(e);
      for (int i = 0; i < 4; i++) begin
         // Busy-time requests must be ignored.
         in_valid = (i < 3);
         in_op    = 3'($urandom);
         in_a     = 16'($urandom);
         in_b     = 16'($urandom);
         in_cin   = 1'($urandom);
         @(negedge clk);
         chk_eq($sformatf("run_alu_idx%0d", i), {alu_a, alu_b, alu_c, alu_cin},
                exp_alu(op, a, b, cin, i));
         chk_eq("run_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while (q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL drain: got %0d outstanding responses, required 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rdy_mode == 0)      out_ready = 1'($urandom);
         else if (rdy_mode == 1) out_ready = 1'b0;
         else                    out_ready = 1'b1;
      end
   end

   // Response monitor
   always @(negedge clk) begin
      if (rst) begin
         mon_seen = 1'b0;
      end else begin
         if (in_ready) chk_eq("idle_alu_zero", {alu_a, alu_b, alu_c, alu_cin}, 0);
         if (out_valid) begin
            chk_eq("done_in_ready", in_ready, 0);
            if (!mon_seen) begin
               if (q.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL unexpected_response: got result %h, required no response",
                           out_result);
               end else begin
                  mon_e = q[0];
                  chk_eq("latency", cyc - mon_e.acc, 5);
                  chk_eq("result", out_result, mon_e.res);
                  chk_eq("zero", out_zero, mon_e.z);
                  chk_eq("carry", out_carry, mon_e.c);
                  chk_eq("overflow", out_overflow, mon_e.v);
               end
               mon_hold = {out_result, out_zero, out_carry, out_overflow};
               mon_seen = 1'b1;
            end else begin
               chk_eq("hold_stable", {out_result, out_zero, out_carry, out_overflow}, mon_hold);
            end
            if (out_ready) begin
               mon_seen = 1'b0;
               if (q.size() != 0) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      in_valid = 1'b0;
      in_op = 3'd0;
      in_a = 16'h0;
      in_b = 16'h0;
      in_cin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_eq("reset_out_valid", out_valid, 0);
      chk_eq("reset_out_result", out_result, 0);
      chk_eq("reset_flags", {out_zero, out_carry, out_overflow}, 0);
      chk_eq("reset_alu", {alu_a, alu_b, alu_c, alu_cin}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_eq("in_ready_after_reset", in_ready, 1);

      issue(T_ADD, 16'h0FFF, 16'h0001, 1'b0);
      issue(T_SUB, 16'h8000, 16'h0001, 1'b0);
      issue(T_SLT, 16'hFFFF, 16'h0001, 1'b0);
      issue(T_SEQ, 16'h1234, 16'h1234, 1'b0);
      issue(T_ADD, 16'h7FFF, 16'h7FFF, 1'b1);
      wait_drain(100);

      // Stall the response for three cycles
      rdy_mode = 1;
      issue(T_XOR, 16'hA5A5, 16'hFFFF, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         chk_eq("stall_out_valid", out_valid, 1);
         chk_eq("stall_result", out_result, 16'h5A5A);
         chk_eq("stall_in_ready", in_ready, 0);
         @(negedge clk);
      end
      rdy_mode = 2;
      wait_drain(20);
      rdy_mode = 0;

      // Reset during nibble 2: the operation must vanish
      in_valid = 1'b1;
      in_op = T_SUB;
      in_a = 16'h4321;
      in_b = 16'h1111;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("pre_reset_idx2_alu_a", alu_a, 4'h3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_eq("midrun_reset_in_ready", in_ready, 1);
      chk_eq("midrun_reset_out_valid", out_valid, 0);
      chk_eq("midrun_reset_out_result", out_result, 0);
      chk_eq("midrun_reset_flags", {out_zero, out_carry, out_overflow}, 0);
      chk_eq("midrun_reset_alu", {alu_a, alu_b, alu_c, alu_cin}, 0);
      repeat (10) @(negedge clk);

      for (int k = 0; k < 40; k++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
         issue(3'($urandom_range(0, 7)), ra, rb, 1'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      rdy_mode = 0;
      wait_drain(200);
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation got no completion, required $finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
